fir_avg_n: RTL and testbench

Parametrised N-tap moving-sum / moving-average FIR for the averaging-filter datapath. It is the generalised successor of the fixed 4-tap carry-save filter, with these additions:
- configurable sample width, tap count and pipeline depth;
- signed arithmetic;
- an input valid qualifier and an output valid flag;
- a priming counter;
- a run-time sum/average mode;
- a synchronous clear.

It sits between the sample source and downstream decimation or compare logic.

---
 rtl/fir_avg_pkg.sv | 49 ++++
 rtl/fir_avg_n_csa.sv | 18 +
 rtl/fir_avg_n.sv | 126 ++++++++++++
 tb/tb_fir_avg_n.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fir_avg_pkg.sv
// rtl/fir_avg_pkg.sv - shared sizing helpers and pipeline record for fir_avg_n
package fir_avg_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int sum_width(input int w, input int n);
    return w + clog2(n);
  endfunction

  // Operand count entering CSA level lvl when reducing n operands 3:2 per level.
  function automatic int n_ops(input int n, input int lvl);
    int k;
    k = n;
    for (int i = 0; i < lvl; i++) k = 2 * (k / 3) + k % 3;
    return k;
  endfunction

  function automatic int tree_levels(input int n);
    int k;
    int l;
    k = n;
    l = 0;
    while (k > 2) begin
      k = 2 * (k / 3) + k % 3;
      l++;
    end
    return l;
  endfunction

  // Register stages placed at tree boundary b (0 = taps, levels = before the final add).
  function automatic int stages_at(input int b, input int levels, input int pipe);
    int c;
    c = 0;
    for (int p = 1; p <= pipe; p++)
      if ((p * (levels + 1)) / (pipe + 1) == b) c++;
    return c;
  endfunction

  typedef struct packed {
    logic valid;
    logic avg_mode;
  } pipe_rec_t;

endpackage

// File: rtl/fir_avg_n_csa.sv
// rtl/fir_avg_n_csa.sv - 3:2 carry-save compressor row
module csa_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] maj;

  assign sum   = x ^ y ^ z;
  assign maj   = (x & y) | (x & z) | (y & z);
  assign carry = maj << 1;

endmodule

// File: rtl/fir_avg_n.sv
// rtl/fir_avg_n.sv - N-tap moving sum / rounded average with priming and clear
module fir_avg_n
  import fir_avg_pkg::*;
#(
  parameter int W    = 16,
  parameter int N    = 4,
  parameter int PIPE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [W-1:0]               a,
  input  logic                       avg_mode,
  input  logic                       clear,
  output logic [sum_width(W,N)-1:0]  s,
  output logic                       out_valid,
  output logic                       primed
);

  localparam int LG = clog2(N);
  localparam int SW = sum_width(W, N);
  localparam int L  = tree_levels(N);
  localparam logic [SW-1:0] HALF = SW'(N / 2);

  logic [W-1:0]    taps [0:N-1];
  logic [LG:0]     fill;
  pipe_rec_t       meta [0:PIPE];
  logic            accept;

  assign accept = in_valid & ~clear;
  assign primed = (fill == (LG+1)'(N));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) taps[k] <= '0;
      fill <= '0;
    end else if (clear) begin
      for (int k = 0; k < N; k++) taps[k] <= '0;
      fill <= '0;
    end else if (in_valid) begin
      taps[0] <= a;
      for (int k = 1; k < N; k++) taps[k] <= taps[k-1];
      if (!primed) fill <= fill + (LG+1)'(1);
    end
  end

  // Only samples landing on a full window produce a valid result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j <= PIPE; j++) meta[j] <= '0;
    end else if (clear) begin
      for (int j = 0; j <= PIPE; j++) meta[j] <= '0;
    end else begin
      meta[0] <= {accept & (fill >= (LG+1)'(N-1)), avg_mode};
      for (int j = 1; j <= PIPE; j++) meta[j] <= meta[j-1];
    end
  end

  // lv_c[b]: operands produced at boundary b; lv[b]: same after any pipeline stages there.
  logic [N*SW-1:0] lv_c [0:L];
  logic [N*SW-1:0] lv   [0:L];

  for (genvar i = 0; i < N; i++) begin : g_ext
    assign lv_c[0][i*SW +: SW] = {{LG{taps[i][W-1]}}, taps[i]};
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int NI = n_ops(N, l);
    localparam int G  = NI / 3;
    localparam int R  = NI % 3;
    localparam int NO = 2 * G + R;
    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2 #(.WIDTH(SW)) u_csa (
        .x     (lv[l][(3*g)*SW +: SW]),
        .y     (lv[l][(3*g+1)*SW +: SW]),
        .z     (lv[l][(3*g+2)*SW +: SW]),
        .sum   (lv_c[l+1][(2*g)*SW +: SW]),
        .carry (lv_c[l+1][(2*g+1)*SW +: SW])
      );
    end
    for (genvar r = 0; r < R; r++) begin : g_pass
      assign lv_c[l+1][(2*G+r)*SW +: SW] = lv[l][(3*G+r)*SW +: SW];
    end
    if (NO < N) begin : g_zero
      assign lv_c[l+1][N*SW-1:NO*SW] = '0;
    end
  end

  for (genvar b = 0; b <= L; b++) begin : g_bnd
    localparam int K = stages_at(b, L, PIPE);
    if (K == 0) begin : g_wire
      assign lv[b] = lv_c[b];
    end else begin : g_reg
      logic [N*SW-1:0] dly [0:K-1];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int j = 0; j < K; j++) dly[j] <= '0;
        end else begin
          dly[0] <= lv_c[b];
          for (int j = 1; j < K; j++) dly[j] <= dly[j-1];
        end
      end
      assign lv[b] = dly[K-1];
    end
  end

  logic signed [SW-1:0] sum_c;
  logic signed [SW-1:0] rnd_c;
  logic signed [SW-1:0] avg_c;

  assign sum_c = lv[L][SW-1:0] + lv[L][2*SW-1:SW];
  assign rnd_c = sum_c + HALF;
  assign avg_c = rnd_c >>> LG;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= meta[PIPE].valid & ~clear;
      if (meta[PIPE].valid && !clear)
        s <= meta[PIPE].avg_mode ? avg_c : sum_c;
    end
  end

endmodule

// File: tb/tb_fir_avg_n.sv
// tb/tb_fir_avg_n.sv - directed bench for fir_avg_n, PIPE=0 and PIPE=2 side by side
module tb_fir_avg_n;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic [15:0]        a;
  logic               avg_mode;
  logic               clear;
  logic signed [17:0] s0, s2;
  logic               ov0, ov2, pr0, pr2;

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int pulses2 = 0;

  fir_avg_n #(.W(16), .N(4), .PIPE(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .avg_mode(avg_mode),
    .clear(clear), .s(s0), .out_valid(ov0), .primed(pr0)
  );

  fir_avg_n #(.W(16), .N(4), .PIPE(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .avg_mode(avg_mode),
    .clear(clear), .s(s2), .out_valid(ov2), .primed(pr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ov0) pulses0++;
    if (ov2) pulses2++;
  endtask

  task automatic send(input int v, input logic m);
    in_valid = 1'b1;
    a        = 16'(v);
    avg_mode = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; a = '0; avg_mode = 1'b0; clear = 1'b0;
    #3;
    chk("rst_s0", s0, 0);
    chk("rst_ov0", ov0, 0);
    chk("rst_pr0", pr0, 0);
    chk("rst_ov2", ov2, 0);
    #9 reset = 1'b1;
    @(negedge clk);

    // sum mode 1..6
    send(1, 0); chk("t1_ov_a", ov0, 0);
    send(2, 0); chk("t1_ov_b", ov0, 0);
    send(3, 0); chk("t1_ov_c", ov0, 0); chk("t1_pr3", pr0, 0);
    send(4, 0); chk("t1_ov_d", ov0, 0); chk("t1_pr4", pr0, 1);
    send(5, 0); chk("t1_ov10", ov0, 1); chk("t1_s10", s0, 10);
    send(6, 0); chk("t1_s14", s0, 14);
    idle();     chk("t1_s18", s0, 18); chk("t1_ov18", ov0, 1);
    idle();     chk("t1_ov_off", ov0, 0); chk("t1_hold", s0, 18);

    // extremes
    do_clear();
    for (int i = 0; i < 4; i++) send(-32768, 0);
    chk("t2_ov_pre", ov0, 0);
    idle();
    chk("t2_min", s0, -131072);
    chk("t2_min_bits", longint'(u0.s), longint'(18'h20000));
    for (int i = 0; i < 4; i++) send(32767, 0);
    idle();
    chk("t2_max", s0, 131068);

    // average mode
    do_clear();
    send(1, 1); send(2, 1); send(3, 1); send(4, 1); idle();
    chk("t3_avg3", s0, 3);
    send(-1, 1); send(-1, 1); send(-1, 1); send(-2, 1); idle();
    chk("t3_avg_m1", s0, -1);
    send(2, 1); send(2, 1); send(2, 1); send(3, 1); idle();
    chk("t3_avg2", s0, 2);
    send(5, 0);
    send(6, 1); chk("t3_mode_sum", s0, 12);
    idle();     chk("t3_mode_avg", s0, 4);

    // bubbles
    do_clear();
    pulses0 = 0; pulses2 = 0;
    send(1, 0); idle(); send(2, 0); idle(); idle(); send(3, 0); send(4, 0);
    chk("t4_ov0_e", ov0, 0); chk("t4_ov2_e", ov2, 0);
    idle(); chk("t4_ov0_e1", ov0, 1); chk("t4_s0", s0, 10); chk("t4_ov2_e1", ov2, 0);
    idle(); chk("t4_ov0_e2", ov0, 0); chk("t4_ov2_e2", ov2, 0);
    idle(); chk("t4_ov2_e3", ov2, 1); chk("t4_s2", s2, 10);
    idle(); chk("t4_ov2_e4", ov2, 0);
    chk("t4_pulses0", pulses0, 1);
    chk("t4_pulses2", pulses2, 1);

    // clear with the 6th sample
    do_clear();
    for (int i = 1; i <= 5; i++) send(i, 0);
    chk("t5_s10", s0, 10);
    clear = 1'b1;
    send(6, 0);
    clear = 1'b0;
    chk("t5_ov_clr", ov0, 0); chk("t5_pr_clr", pr0, 0); chk("t5_s_hold", s0, 10);
    idle(); chk("t5_ov_next", ov0, 0);
    send(7, 0); send(8, 0); send(9, 0);
    chk("t5_pr3", pr0, 0);
    send(10, 0); chk("t5_ov_pre", ov0, 0); chk("t5_pr4", pr0, 1);
    idle(); chk("t5_ov", ov0, 1); chk("t5_s34", s0, 34);

    // asynchronous reset mid-stream
    send(11, 0); send(12, 0);
    chk("t6_pre_ov", ov0, 1); chk("t6_pre_s", s0, 38);
    #2 reset = 1'b0;
    #1;
    chk("t6_s0", s0, 0); chk("t6_ov0", ov0, 0); chk("t6_pr0", pr0, 0);
    chk("t6_s2", s2, 0); chk("t6_pr2", pr2, 0);
    #1 reset = 1'b1;
    send(1, 0); send(2, 0); send(3, 0);
    chk("t6_ov_pre", ov0, 0);
    send(4, 0); chk("t6_pr", pr0, 1);
    idle(); chk("t6_ov", ov0, 1); chk("t6_s", s0, 10);
    idle(); idle(); chk("t6_s2_ok", s2, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
